bram_burst_ctrl: RTL

- Command front-end sitting directly upstream of the block BRAM (`bram`, 16-bit words, 256*NUM_BLOCKS deep).
- Accepts one burst command at a time (read or write, start address, length).
- Streams write data into the BRAM's write port, or streams read data out of its 1-cycle-latency read port.
- Read path has valid/ready backpressure and sustains 1 word/cycle.

---
 rtl/bram_ctrl_pkg.sv | 20 ++
 rtl/bram_rd_fifo2.sv | 67 ++++++
 rtl/bram_burst_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM burst controller: controller states,
// the data word width and the derivation of the word address width.
package bram_ctrl_pkg;

    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Word address width for a memory built from 256-word blocks.
    function automatic int calc_addr_w(input int num_blocks);
        return $clog2(BLOCK_WORDS) + $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/bram_rd_fifo2.sv
// Two-entry FIFO that catches read returns from the BRAM. The head entry
// drives the read data port directly, so the word is stable until popped.
module bram_rd_fifo2
    import bram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              valid,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count_q;

    // Storage and occupancy update for push, pop, or both in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            // NOTE: the two data registers are reset as well, so the read
            // data port shows 0 rather than stale data after reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q  <= din;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_q  <= din;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        head_q  <= tail_q;
                        count_q <= count_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        // Pop of the only word (or a spurious pop when
                        // empty): the pushed word becomes the new head.
                        head_q  <= din;
                        count_q <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = count_q;
    assign valid = (count_q != 2'd0);
    assign head  = head_q;

endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst command front-end for a block BRAM. Accepts one read or write burst
// at a time, streams write words straight into the BRAM write port and
// streams read words out through a credit-limited two-entry return FIFO.
module bram_burst_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int NUM_BLOCKS = 16,
    localparam int ADDR_W     = calc_addr_w(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic              pop;
    logic [2:0]        credit_used;
    logic              credit_ok;

    // Read returns land in the FIFO the cycle after the BRAM read enable.
    bram_rd_fifo2 u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (mem_rd_data),
        .pop   (pop),
        .count (fifo_count),
        .valid (fifo_valid),
        .head  (rdata)
    );

    assign rdata_valid = fifo_valid & ~rst;
    assign pop         = rdata_valid & rdata_ready;
    assign busy        = (state_q != ST_IDLE);

    // Words held or on their way back may not exceed the FIFO depth once
    // this cycle's pop is accounted for.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok   = (credit_used < (3'd2 + {2'b00, pop}));

    // Next-state, address/length bookkeeping and BRAM port drive.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wdata_ready = ~rst;
                if (wdata_valid && !rst) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = cur_addr_q;
                    mem_wr_data = wdata;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (credit_ok && !rst) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = cur_addr_q;
                    inflight_d  = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q &&
                    (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers; reset aborts any burst immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule
